uart_frame_chk: RTL and testbench

Parametrised UART receive-frame checker: after start-bit validation it consumes the mid-bit samples of one frame. It assembles the data word LSB-first, checks optional even/odd parity and one or two stop bits, and detects break frames. It also keeps saturating per-error-type counters. It sits in the UART RX path between the edge/bit counter plus data sampler and the RX output register, replacing the standalone stop-bit check with a full per-frame checker.

---
 rtl/uart_frame_chk.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_chk.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_chk.sv
// UART receive-frame checker: assembles LSB-first data, checks parity and stop
// bits, flags break frames and keeps saturating per-error counters.
module uart_frame_chk #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_TWO,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  frame_done,
    output logic                  frame_valid,
    output logic                  busy,
    output logic                  Parity_Error,
    output logic                  Stop_Error,
    output logic                  Break_Detect,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  brk_cnt
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state, state_nxt;

    logic                  par_en_q, par_typ_q, stop_two_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_cnt;
    logic                  par_flag, stop_flag, nz_flag, brk_flag;

    logic bit_take, par_exp, complete;
    logic brk_now, stop_now, par_now;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; frame_start overrides any coincident strobe
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = DATA;
        end else if (bit_valid) begin
            case (state)
                DATA: begin
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        state_nxt = par_en_q ? PARITY : STOP1;
                    end
                end
                PARITY: state_nxt = STOP1;
                STOP1:  state_nxt = stop_two_q ? STOP2 : IDLE;
                STOP2:  state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Output / completion logic, including the contribution of the current strobe
    always_comb begin
        bit_take = bit_valid & ~frame_start;
        par_exp  = par_typ_q ? ~^shift_q : ^shift_q;
        complete = bit_take & (((state == STOP1) & ~stop_two_q) | (state == STOP2));
        brk_now  = (state == STOP1) ? (~nz_flag & ~sampled_bit) : brk_flag;
        stop_now = stop_flag | ~sampled_bit;
        par_now  = par_flag & ~brk_now;
        busy     = (state != IDLE);
    end

    // Frame datapath and result registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            stop_two_q   <= 1'b0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            par_flag     <= 1'b0;
            stop_flag    <= 1'b0;
            nz_flag      <= 1'b0;
            brk_flag     <= 1'b0;
            P_DATA       <= '0;
            frame_done   <= 1'b0;
            frame_valid  <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            Break_Detect <= 1'b0;
        end else begin
            frame_done  <= complete;
            frame_valid <= complete & ~stop_now & ~par_now & ~brk_now;
            if (frame_start) begin
                par_en_q     <= PAR_EN;
                par_typ_q    <= PAR_TYP;
                stop_two_q   <= STOP_TWO;
                bit_cnt      <= '0;
                par_flag     <= 1'b0;
                stop_flag    <= 1'b0;
                nz_flag      <= 1'b0;
                brk_flag     <= 1'b0;
                Parity_Error <= 1'b0;
                Stop_Error   <= 1'b0;
                Break_Detect <= 1'b0;
            end else if (bit_valid) begin
                case (state)
                    DATA: begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        nz_flag <= nz_flag | sampled_bit;
                    end
                    PARITY: begin
                        par_flag <= par_flag | (sampled_bit != par_exp);
                        nz_flag  <= nz_flag | sampled_bit;
                    end
                    STOP1: begin
                        stop_flag <= stop_now;
                        brk_flag  <= brk_now;
                    end
                    STOP2: begin
                        stop_flag <= stop_now;
                    end
                    default: ;
                endcase
                if (complete) begin
                    P_DATA       <= shift_q;
                    Parity_Error <= par_now;
                    Stop_Error   <= stop_now;
                    Break_Detect <= brk_now;
                end
            end
        end
    end

    // Saturating error counters; clear has priority over increment
    always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
            stop_err_cnt <= '0;
            par_err_cnt  <= '0;
            brk_cnt      <= '0;
        end else if (complete) begin
            if (stop_now && (stop_err_cnt != '1)) stop_err_cnt <= stop_err_cnt + 1'b1;
            if (par_now && (par_err_cnt != '1))   par_err_cnt  <= par_err_cnt + 1'b1;
            if (brk_now && (brk_cnt != '1))       brk_cnt      <= brk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_frame_chk.sv
// Directed bench for uart_frame_chk with hand-computed expected results.
module tb_uart_frame_chk;

    logic       CLK = 1'b0;
    logic       RST, frame_start, bit_valid, sampled_bit;
    logic       PAR_EN, PAR_TYP, STOP_TWO, cnt_clr;
    logic [7:0] P_DATA;
    logic       frame_done, frame_valid, busy;
    logic       Parity_Error, Stop_Error, Break_Detect;
    logic [1:0] stop_err_cnt, par_err_cnt, brk_cnt;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (frame_done) done_cnt <= done_cnt + 1;

    uart_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .STOP_TWO(STOP_TWO), .cnt_clr(cnt_clr), .P_DATA(P_DATA),
        .frame_done(frame_done), .frame_valid(frame_valid), .busy(busy),
        .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
        .Break_Detect(Break_Detect), .stop_err_cnt(stop_err_cnt),
        .par_err_cnt(par_err_cnt), .brk_cnt(brk_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic clr);
        bit_valid = 1'b1; sampled_bit = b; cnt_clr = clr;
        @(negedge CLK);
        bit_valid = 1'b0; sampled_bit = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic start(input logic pe, input logic pt, input logic st);
        frame_start = 1'b1; PAR_EN = pe; PAR_TYP = pt; STOP_TWO = st;
        @(negedge CLK);
        frame_start = 1'b0;
    endtask

    // Returns in the cycle after the last strobe, where results are visible
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic st, input logic pb, input logic s1,
                              input logic s2, input logic clr_last);
        start(pe, pt, st);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], 1'b0);
            if (i == 3) @(negedge CLK);
        end
        if (pe) send_bit(pb, 1'b0);
        if (st) begin
            send_bit(s1, 1'b0);
            send_bit(s2, clr_last);
        end else begin
            send_bit(s1, clr_last);
        end
    endtask

    task automatic chk_result(input string tag, input logic [7:0] pd, input logic pe,
                              input logic se, input logic bk, input logic fv);
        check({tag, ".done"},  frame_done, 1'b1);
        check({tag, ".valid"}, frame_valid, fv);
        check({tag, ".pdata"}, P_DATA, pd);
        check({tag, ".perr"},  Parity_Error, pe);
        check({tag, ".serr"},  Stop_Error, se);
        check({tag, ".brk"},   Break_Detect, bk);
        check({tag, ".busy"},  busy, 1'b0);
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] s, input logic [1:0] p,
                           input logic [1:0] b);
        check({tag, ".stop_cnt"}, stop_err_cnt, s);
        check({tag, ".par_cnt"},  par_err_cnt, p);
        check({tag, ".brk_cnt"},  brk_cnt, b);
    endtask

    initial begin
        RST = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_TWO = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst.pdata", P_DATA, 8'h00);
        check("rst.done", frame_done, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.serr", Stop_Error, 1'b0);
        chk_cnt("rst", 2'd0, 2'd0, 2'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Clean even-parity frame 0xA5
        send_frame(8'hA5, 1, 0, 0, 0, 1, 0, 0);
        chk_result("a5", 8'hA5, 0, 0, 0, 1);
        chk_cnt("a5", 2'd0, 2'd0, 2'd0);
        @(negedge CLK);
        check("a5.done_pulse", frame_done, 1'b0);
        check("a5.hold", P_DATA, 8'hA5);

        // Parity error, then odd parity accepted (back-to-back)
        send_frame(8'hA5, 1, 0, 0, 1, 1, 0, 0);
        chk_result("perr", 8'hA5, 1, 0, 0, 0);
        chk_cnt("perr", 2'd0, 2'd1, 2'd0);
        send_frame(8'hA5, 1, 1, 0, 1, 1, 0, 0);
        chk_result("odd", 8'hA5, 0, 0, 0, 1);
        chk_cnt("odd", 2'd0, 2'd1, 2'd0);

        // Two stop bits, second one bad
        send_frame(8'h3C, 0, 0, 1, 0, 1, 0, 0);
        chk_result("stop2", 8'h3C, 0, 1, 0, 0);
        chk_cnt("stop2", 2'd1, 2'd1, 2'd0);

        // Break with odd parity: parity mismatch must be masked
        send_frame(8'h00, 1, 1, 0, 0, 0, 0, 0);
        chk_result("brk", 8'h00, 0, 1, 1, 0);
        chk_cnt("brk", 2'd2, 2'd1, 2'd1);
        start(0, 0, 0);
        check("brk.clr_serr", Stop_Error, 1'b0);
        check("brk.clr_brk", Break_Detect, 1'b0);
        check("start.busy", busy, 1'b1);

        // Abort after 4 bits, then a clean 0x5A
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_frame(8'h5A, 1, 0, 0, 0, 1, 0, 0);
        chk_result("abort", 8'h5A, 0, 0, 0, 1);
        @(negedge CLK);
        check("abort.ndone", done_cnt - d0, 1);
        chk_cnt("abort", 2'd2, 2'd1, 2'd1);

        // frame_start coincident with bit_valid drops that bit
        start(0, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        frame_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk_result("coinc", 8'h5A, 0, 0, 0, 1);

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        @(negedge CLK);
        cnt_clr = 1'b0;
        chk_cnt("clr", 2'd0, 2'd0, 2'd0);
        for (int k = 0; k < 5; k++) send_frame(8'h01, 0, 0, 0, 0, 0, 0, 0);
        chk_result("sat", 8'h01, 0, 1, 0, 0);
        chk_cnt("sat", 2'd3, 2'd0, 2'd0);
        send_frame(8'h01, 0, 0, 0, 0, 0, 0, 1);
        chk_result("clrpri", 8'h01, 0, 1, 0, 0);
        chk_cnt("clrpri", 2'd0, 2'd0, 2'd0);

        // Reset mid-frame
        @(negedge CLK);
        d0 = done_cnt;
        start(0, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mrst.busy", busy, 1'b0);
        check("mrst.pdata", P_DATA, 8'h00);
        send_bit(1'b1, 1'b0);
        check("idle.ignore", busy, 1'b0);
        repeat (3) @(negedge CLK);
        check("mrst.ndone", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
